keypad_scanner: RTL
===================

Name: keypad_scanner

Overview:
- Input-side counterpart of the multiplexed 7-segment display driver. The display scans digit strobes out; this block scans keypad columns out and reads rows in.
- Scans a 4x4 active-low matrix keypad, synchronizes and debounces presses, and emits one key code pulse per press.
- Accumulates up to three decimal digits into a 10-bit value (0-999). The value feeds the same 10-bit numeric paths the display consumes (setpoint/power entry).

Parameters:
- SCAN_DIV, 100000, clk cycles per column dwell. The end of each dwell is a "tick" (1 kHz at 100 MHz).
- DEBOUNCE_SCANS, 4, consecutive matching ticks required to accept a press or a release (>=1).
- REPEAT_DELAY, 500, ticks held before the first auto-repeat (only used with KEYPAD_REPEAT_EN).
- REPEAT_RATE, 100, ticks between repeats (only used with KEYPAD_REPEAT_EN).

Ports:
- clk  in  1  system clock.
- rst  in  1  reset, asynchronous, active-low.
- col_n  out  4  column drive, one-hot-low; 0 = column driven.
- row_n  in  4  row sense, active-low, asynchronous to clk.
- key_valid  out  1  one-cycle pulse; key_code is valid in the same cycle.
- key_code  out  4  last accepted key.
- entry_val  out  10  accumulated decimal value.
- entry_digits  out  2  digits entered so far (0-3).
- entry_done  out  1  one-cycle pulse on Enter; entry_val holds the submitted value in that cycle.

Behaviour:
- Reset (rst=0, async) sets: col_n=4'b1110, key_valid=0, key_code=0, entry_val=0, entry_digits=0, entry_done=0, state=SCAN, all counters 0.
- row_n passes through a 2-FF synchronizer before any use. A press therefore lands 2 cycles late relative to a tick.
- The tick counter counts 0..SCAN_DIV-1 and ticks on SCAN_DIV-1, then wraps.
- Keymap (row r, col c), codes 0-9 = digits:
  - r0: 1 2 3 A(10)
  - r1: 4 5 6 B(11)
  - r2: 7 8 9 C(12)
  - r3: *(14, clear) 0 #(15, enter). D maps to 13.
- A sample is "single press" when exactly one synced row is low. Zero or two-or-more rows low counts as "no press".
- FSM:
  - SCAN: on each tick, if single press, latch row/col and go to DEBOUNCE with cnt=1; col_n stays frozen. Otherwise rotate col_n left by one (1110→1101→1011→0111→1110).
  - DEBOUNCE: on each tick, if the same row is still single-pressed, cnt++. When cnt reaches DEBOUNCE_SCANS, pulse key_valid the next cycle with key_code=map(row,col) and go to HELD. On any mismatch or release, go to SCAN and rotate to the next column. When DEBOUNCE_SCANS=1, the press is accepted directly from SCAN.
  - HELD: column stays frozen. Each tick with all rows high increments the release count; any low row clears it. When the count reaches DEBOUNCE_SCANS, go to SCAN and resume rotation from the next column. No further key_valid is produced in HELD.
- Accumulator (acts in the cycle after key_valid):
  - Digit d with entry_digits<3: entry_val = entry_val*10 + d; entry_digits++. Multiply as (x<<3)+(x<<1) at 10-bit width; the maximum 999 fits.
  - Digit d with entry_digits==3: ignored.
  - 14 (*): entry_val=0, entry_digits=0.
  - 15 (#): entry_done=1 for one cycle with the current entry_val, then entry_val=0 and entry_digits=0 on the following cycle. Enter with 0 digits still pulses, with entry_val=0.
  - 10-13: no effect on the accumulator.
- A key held through reset release is re-debounced from SCAN and reported exactly once.

Optional Feature:
- Macro: KEYPAD_REPEAT_EN.
- Defined: in HELD, a held-tick counter runs. When it reaches REPEAT_DELAY, key_valid pulses again with the same code; after that it pulses every REPEAT_RATE ticks until release is accepted. Repeats feed the accumulator like normal presses.
- Undefined: exactly one key_valid per press. No repeat counters are synthesized.

Decomposition:
- Package keypad_pkg holds:
  - state encoding SCAN/DEBOUNCE/HELD;
  - constants KEY_CLEAR=4'd14, KEY_ENTER=4'd15, COL_RESET=4'b1110;
  - a keymap function (row, col) -> code.
- Sub-module keypad_entry holds the digit accumulator and entry_done logic. keypad_scanner instantiates it, driving it from key_valid/key_code.

Test Plan (SCAN_DIV=4, DEBOUNCE_SCANS=2):
- Release rst with no keys pressed → col_n cycles 1110,1101,1011,0111 every 4 clk; all other outputs stay 0.
- Hold row1 low only while col2 is driven, for 20 ticks, then release → exactly one key_valid with key_code=6; entry_val=6 and entry_digits=1; col_n resumes rotation after 2 release ticks.
- Hold row0 low for 1 tick, then release (bounce) → no key_valid; scanning continues.
- Press 1,2,3,4,# → entry_val 1,12,123; '4' is ignored; entry_done pulses with entry_val=123, then entry_val=0 and entry_digits=0.
- Press 5,7,* → entry_val=57, then 0; no entry_done. Hold row0 and row2 low together in col0 → no key_valid.
- Assert rst mid-DEBOUNCE → col_n=1110 immediately and no key_valid. If the key is still held after release, exactly one key_valid follows.

Source files
------------

// File: rtl/keypad_pkg.sv
// keypad_pkg: shared definitions for the 4x4 matrix keypad scanner.
//   state_t     - scanner FSM states (SCAN / DEBOUNCE / HELD)
//   KEY_CLEAR   - code of the '*' key (clears the numeric entry)
//   KEY_ENTER   - code of the '#' key (submits the numeric entry)
//   COL_RESET   - column drive pattern after reset (column 0 driven)
//   keymap()    - (row, col) -> 4-bit key code
//   decode_row()- {single_press, row_index} from an active-low row sample
package keypad_pkg;

  typedef enum logic [1:0] {
    SCAN     = 2'd0,
    DEBOUNCE = 2'd1,
    HELD     = 2'd2
  } state_t;

  localparam logic [3:0] KEY_CLEAR = 4'd14;
  localparam logic [3:0] KEY_ENTER = 4'd15;
  localparam logic [3:0] COL_RESET = 4'b1110;

  // Physical key layout: rows top to bottom, columns left to right.
  function automatic logic [3:0] keymap(input logic [1:0] row, input logic [1:0] col);
    logic [3:0] code;
    case ({row, col})
      4'h0:    code = 4'd1;
      4'h1:    code = 4'd2;
      4'h2:    code = 4'd3;
      4'h3:    code = 4'd10;
      4'h4:    code = 4'd4;
      4'h5:    code = 4'd5;
      4'h6:    code = 4'd6;
      4'h7:    code = 4'd11;
      4'h8:    code = 4'd7;
      4'h9:    code = 4'd8;
      4'hA:    code = 4'd9;
      4'hB:    code = 4'd12;
      4'hC:    code = KEY_CLEAR;
      4'hD:    code = 4'd0;
      4'hE:    code = KEY_ENTER;
      4'hF:    code = 4'd13;
      default: code = 4'd0;
    endcase
    return code;
  endfunction

  // Exactly one low row is a press; none or several low rows are ignored
  // (several rows means ghosting or a multi-key chord).
  function automatic logic [2:0] decode_row(input logic [3:0] rows_n);
    logic [2:0] dec;
    case (rows_n)
      4'b1110: dec = 3'b100;
      4'b1101: dec = 3'b101;
      4'b1011: dec = 3'b110;
      4'b0111: dec = 3'b111;
      default: dec = 3'b000;
    endcase
    return dec;
  endfunction

endpackage

// File: rtl/keypad_if.sv
// keypad_if: keypad pins plus the decoded key / numeric-entry outputs.
//   col_n        column drive, one-hot-low
//   row_n        row sense, active-low, asynchronous
//   key_valid    one-cycle pulse, key_code valid alongside
//   key_code     last accepted key
//   entry_val    accumulated decimal value 0-999
//   entry_digits digits entered so far 0-3
//   entry_done   one-cycle pulse on Enter with the submitted entry_val
// master = scanner side, slave = keypad hardware / consumer side.
interface keypad_if;
  logic [3:0] col_n;
  logic [3:0] row_n;
  logic       key_valid;
  logic [3:0] key_code;
  logic [9:0] entry_val;
  logic [1:0] entry_digits;
  logic       entry_done;

  modport master (
    output col_n, key_valid, key_code, entry_val, entry_digits, entry_done,
    input  row_n
  );

  modport slave (
    input  col_n, key_valid, key_code, entry_val, entry_digits, entry_done,
    output row_n
  );
endinterface

// File: rtl/keypad_entry.sv
// keypad_entry: three-digit decimal accumulator fed by accepted key codes.
//   clk, rst      clock, asynchronous active-low reset
//   key_valid     accepted-key pulse from the scanner
//   key_code      code accompanying key_valid
//   entry_val     accumulated value (0-999)
//   entry_digits  number of digits accumulated (0-3)
//   entry_done    one-cycle pulse on Enter; entry_val is the submitted value
module keypad_entry
  import keypad_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic       key_valid,
  input  logic [3:0] key_code,
  output logic [9:0] entry_val,
  output logic [1:0] entry_digits,
  output logic       entry_done
);

  logic [9:0] val_r, val_s, base_val_s;
  logic [1:0] dig_r, dig_s, base_dig_s;
  logic       done_r, done_s;

  // Next-value logic for the accumulator and the Enter pulse
  always_comb begin
    // The entry is cleared in the cycle after entry_done so the consumer
    // sees the submitted value while the pulse is high.
    if (done_r) begin
      base_val_s = 10'd0;
      base_dig_s = 2'd0;
    end else begin
      base_val_s = val_r;
      base_dig_s = dig_r;
    end
    val_s  = base_val_s;
    dig_s  = base_dig_s;
    done_s = 1'b0;
    if (key_valid) begin
      case (key_code)
        4'd0, 4'd1, 4'd2, 4'd3, 4'd4, 4'd5, 4'd6, 4'd7, 4'd8, 4'd9: begin
          if (base_dig_s < 2'd3) begin
            // x*10 as (x<<3)+(x<<1); 99*10+9 = 999 still fits 10 bits
            val_s = (base_val_s << 3) + (base_val_s << 1) + {6'd0, key_code};
            dig_s = base_dig_s + 2'd1;
          end else begin
            val_s = base_val_s;
          end
        end
        KEY_CLEAR: begin
          val_s = 10'd0;
          dig_s = 2'd0;
        end
        KEY_ENTER: begin
          done_s = 1'b1;
        end
        default: begin
          val_s = base_val_s;
        end
      endcase
    end else begin
      done_s = 1'b0;
    end
  end

  // Accumulator registers
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      val_r  <= 10'd0;
      dig_r  <= 2'd0;
      done_r <= 1'b0;
    end else begin
      val_r  <= val_s;
      dig_r  <= dig_s;
      done_r <= done_s;
    end
  end

  assign entry_val    = val_r;
  assign entry_digits = dig_r;
  assign entry_done   = done_r;

endmodule

// File: rtl/keypad_scanner.sv
// keypad_scanner: scans a 4x4 active-low matrix keypad, debounces presses
// and releases, reports one key code per press and accumulates decimal
// entry through keypad_entry.
//   clk, rst  clock, asynchronous active-low reset
//   kp        keypad_if.master (col_n out, row_n in, key/entry outputs)
// Build option: define KEYPAD_REPEAT_EN to enable auto-repeat while a key
// is held (REPEAT_DELAY ticks to the first repeat, then every REPEAT_RATE).
module keypad_scanner
  import keypad_pkg::*;
#(
  parameter int SCAN_DIV       = 100000,
  parameter int DEBOUNCE_SCANS = 4
`ifdef KEYPAD_REPEAT_EN
  ,
  parameter int REPEAT_DELAY   = 500,
  parameter int REPEAT_RATE    = 100
`endif
) (
  input  logic     clk,
  input  logic     rst,
  keypad_if.master kp
);

  localparam int DIV_W = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam int CNT_W = $clog2(DEBOUNCE_SCANS + 1);
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(SCAN_DIV - 1);
  localparam logic [CNT_W-1:0] DB_LAST  = CNT_W'(DEBOUNCE_SCANS);

  logic [3:0]       row_meta_r, row_sync_r;
  logic [DIV_W-1:0] div_r;
  logic             tick_s;
  logic [2:0]       dec_s;
  logic             press_s;
  logic [1:0]       press_row_s;

  state_t           state_r, state_s;
  logic [1:0]       col_r, col_s;
  logic [1:0]       row_r, row_s;
  logic [CNT_W-1:0] cnt_r, cnt_s, cnt_inc_s;
  logic             key_valid_r, key_valid_s;
  logic [3:0]       key_code_r, key_code_s;
  logic             accept_s;

`ifdef KEYPAD_REPEAT_EN
  localparam int REP_MAX = (REPEAT_DELAY > REPEAT_RATE) ? REPEAT_DELAY : REPEAT_RATE;
  localparam int REP_W   = $clog2(REP_MAX + 1);
  logic [REP_W-1:0] rep_cnt_r, rep_cnt_s, rep_next_s;
  logic             rep_first_r, rep_first_s;
`endif

  assign tick_s      = (div_r == DIV_LAST);
  assign dec_s       = decode_row(row_sync_r);
  assign press_s     = dec_s[2];
  assign press_row_s = dec_s[1:0];
  assign cnt_inc_s   = cnt_r + CNT_W'(1);

  // Row synchronizer and column-dwell divider
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      row_meta_r <= 4'hF;
      row_sync_r <= 4'hF;
      div_r      <= {DIV_W{1'b0}};
    end else begin
      row_meta_r <= kp.row_n;
      row_sync_r <= row_meta_r;
      div_r      <= tick_s ? {DIV_W{1'b0}} : div_r + DIV_W'(1);
    end
  end

  // Scanner FSM next-state and output logic
  always_comb begin
    state_s     = state_r;
    col_s       = col_r;
    row_s       = row_r;
    cnt_s       = cnt_r;
    key_valid_s = 1'b0;
    key_code_s  = key_code_r;
    accept_s    = 1'b0;
`ifdef KEYPAD_REPEAT_EN
    rep_cnt_s   = rep_cnt_r;
    rep_first_s = rep_first_r;
    rep_next_s  = rep_cnt_r + REP_W'(1);
`endif
    case (state_r)
      SCAN: begin
        if (tick_s) begin
          if (press_s) begin
            row_s = press_row_s;
            cnt_s = CNT_W'(1);
            if (DB_LAST == CNT_W'(1)) begin
              accept_s = 1'b1;
            end else begin
              state_s = DEBOUNCE;
            end
          end else begin
            col_s = col_r + 2'd1;
          end
        end else begin
          state_s = SCAN;
        end
      end
      DEBOUNCE: begin
        if (tick_s) begin
          if (press_s && (press_row_s == row_r)) begin
            if (cnt_inc_s == DB_LAST) begin
              accept_s = 1'b1;
            end else begin
              cnt_s = cnt_inc_s;
            end
          end else begin
            // Bounce or a different row: abandon and move on
            state_s = SCAN;
            cnt_s   = {CNT_W{1'b0}};
            col_s   = col_r + 2'd1;
          end
        end else begin
          state_s = DEBOUNCE;
        end
      end
      HELD: begin
        if (tick_s) begin
          // cnt_r is reused here as the consecutive-release counter
          if (row_sync_r == 4'hF) begin
            if (cnt_inc_s == DB_LAST) begin
              state_s = SCAN;
              cnt_s   = {CNT_W{1'b0}};
              col_s   = col_r + 2'd1;
            end else begin
              cnt_s = cnt_inc_s;
            end
          end else begin
            cnt_s = {CNT_W{1'b0}};
          end
`ifdef KEYPAD_REPEAT_EN
          if (state_s == HELD) begin
            if ((!rep_first_r && rep_next_s == REP_W'(REPEAT_DELAY)) ||
                ( rep_first_r && rep_next_s == REP_W'(REPEAT_RATE))) begin
              key_valid_s = 1'b1;
              rep_cnt_s   = {REP_W{1'b0}};
              rep_first_s = 1'b1;
            end else begin
              rep_cnt_s = rep_next_s;
            end
          end else begin
            rep_cnt_s = {REP_W{1'b0}};
          end
`endif
        end else begin
          state_s = HELD;
        end
      end
      default: begin
        state_s = SCAN;
        cnt_s   = {CNT_W{1'b0}};
      end
    endcase

    if (accept_s) begin
      state_s     = HELD;
      cnt_s       = {CNT_W{1'b0}};
      key_valid_s = 1'b1;
      key_code_s  = keymap(row_s, col_r);
`ifdef KEYPAD_REPEAT_EN
      rep_cnt_s   = {REP_W{1'b0}};
      rep_first_s = 1'b0;
`endif
    end else begin
      key_valid_s = key_valid_s;
    end
  end

  // Scanner FSM state and registered key outputs
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_r     <= SCAN;
      col_r       <= 2'd0;
      row_r       <= 2'd0;
      cnt_r       <= {CNT_W{1'b0}};
      key_valid_r <= 1'b0;
      key_code_r  <= 4'd0;
`ifdef KEYPAD_REPEAT_EN
      rep_cnt_r   <= {REP_W{1'b0}};
      rep_first_r <= 1'b0;
`endif
    end else begin
      state_r     <= state_s;
      col_r       <= col_s;
      row_r       <= row_s;
      cnt_r       <= cnt_s;
      key_valid_r <= key_valid_s;
      key_code_r  <= key_code_s;
`ifdef KEYPAD_REPEAT_EN
      rep_cnt_r   <= rep_cnt_s;
      rep_first_r <= rep_first_s;
`endif
    end
  end

  // Column index 0 maps onto COL_RESET; rotating left walks the low bit up.
  assign kp.col_n     = ~(~COL_RESET << col_r);
  assign kp.key_valid = key_valid_r;
  assign kp.key_code  = key_code_r;

  keypad_entry u_entry (
    .clk          (clk),
    .rst          (rst),
    .key_valid    (key_valid_r),
    .key_code     (key_code_r),
    .entry_val    (kp.entry_val),
    .entry_digits (kp.entry_digits),
    .entry_done   (kp.entry_done)
  );

endmodule
